scan_line_buffer: RTL and testbench

SCAN_LINE_BUFFER -- requirements
Module: scan_line_buffer

---
 rtl/scan_line_buffer.sv | 169 ++++++++++++++++
 tb/tb_scan_line_buffer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_line_buffer.sv
// Scan line buffer: captures one NES line (256 palette indices) while the
// display side reads the previous one, doubling each pixel horizontally and
// converting the palette index to RGB555 on the way out.
//
// Two 256-entry banks live in one 512-deep RAM addressed by {bank, column}.
// The writer owns bank wr_bank_q and the reader always sees the other one.
// in_line_done swaps them. A 2-bit saturating counter tracks how many swaps
// happened since the reader last started a line. A swap while two are
// already pending means a written line was never shown, so overrun latches.
module scan_line_buffer #(
    parameter logic [14:0] PAL_BLACK = 15'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_ce,
    input  logic [7:0]  in_x,
    input  logic [5:0]  in_color,
    input  logic        in_line_done,
    input  logic        in_frame_start,
    input  logic [8:0]  rd_x,
    input  logic        rd_line_start,
    output logic [14:0] pixel,
    output logic        sync,
    output logic        overrun
);

    logic [5:0] line_mem [0:511];

    logic       wr_bank_q,    wr_bank_d;
    logic       line_ready_q, line_ready_d;
    logic [1:0] swap_cnt_q,   swap_cnt_d;
    logic       overrun_q,    overrun_d;
    logic       sync_q,       sync_d;
    logic       rd_valid_q,   rd_valid_d;
    logic [5:0] rd_idx_q,     rd_idx_d;
    logic [1:0] cnt_base;

    // rd_x[0] only picks which half of a doubled pixel is shown.
    logic unused_rd_x0;
    assign unused_rd_x0 = rd_x[0];

    // RGB555 packing helper: {B, G, R}.
    function automatic logic [14:0] rgb(input logic [4:0] r, input logic [4:0] g,
                                        input logic [4:0] b);
        return {b, g, r};
    endfunction

    // 2C02 palette, 8-bit channels truncated to 5 bits; 0x20/0x30 forced to full white.
    function automatic logic [14:0] pal_lookup(input logic [5:0] idx);
        logic [14:0] p;
        case (idx)
            6'h00: p = rgb(5'd10, 5'd10, 5'd10);
            6'h01: p = rgb(5'd0,  5'd3,  5'd14);
            6'h02: p = rgb(5'd1,  5'd2,  5'd18);
            6'h03: p = rgb(5'd6,  5'd0,  5'd17);
            6'h04: p = rgb(5'd8,  5'd0,  5'd12);
            6'h05: p = rgb(5'd11, 5'd0,  5'd6);
            6'h06: p = rgb(5'd10, 5'd0,  5'd0);
            6'h07: p = rgb(5'd7,  5'd3,  5'd0);
            6'h08: p = rgb(5'd4,  5'd5,  5'd0);
            6'h09: p = rgb(5'd1,  5'd7,  5'd0);
            6'h0A: p = rgb(5'd0,  5'd8,  5'd0);
            6'h0B: p = rgb(5'd0,  5'd7,  5'd0);
            6'h0C: p = rgb(5'd0,  5'd6,  5'd7);
            6'h10: p = rgb(5'd19, 5'd18, 5'd19);
            6'h11: p = rgb(5'd1,  5'd9,  5'd24);
            6'h12: p = rgb(5'd6,  5'd6,  5'd29);
            6'h13: p = rgb(5'd11, 5'd3,  5'd28);
            6'h14: p = rgb(5'd17, 5'd2,  5'd22);
            6'h15: p = rgb(5'd20, 5'd2,  5'd12);
            6'h16: p = rgb(5'd19, 5'd4,  5'd4);
            6'h17: p = rgb(5'd15, 5'd7,  5'd0);
            6'h18: p = rgb(5'd10, 5'd11, 5'd0);
            6'h19: p = rgb(5'd5,  5'd14, 5'd0);
            6'h1A: p = rgb(5'd1,  5'd15, 5'd0);
            6'h1B: p = rgb(5'd0,  5'd14, 5'd5);
            6'h1C: p = rgb(5'd0,  5'd12, 5'd15);
            6'h20: p = 15'h7FFF;
            6'h21: p = rgb(5'd9,  5'd19, 5'd29);
            6'h22: p = rgb(5'd15, 5'd15, 5'd29);
            6'h23: p = rgb(5'd22, 5'd12, 5'd29);
            6'h24: p = rgb(5'd28, 5'd10, 5'd29);
            6'h25: p = rgb(5'd29, 5'd11, 5'd22);
            6'h26: p = rgb(5'd29, 5'd13, 5'd12);
            6'h27: p = rgb(5'd26, 5'd17, 5'd4);
            6'h28: p = rgb(5'd20, 5'd21, 5'd0);
            6'h29: p = rgb(5'd14, 5'd24, 5'd0);
            6'h2A: p = rgb(5'd9,  5'd26, 5'd4);
            6'h2B: p = rgb(5'd7,  5'd25, 5'd13);
            6'h2C: p = rgb(5'd7,  5'd22, 5'd25);
            6'h2D: p = rgb(5'd7,  5'd7,  5'd7);
            6'h30: p = 15'h7FFF;
            6'h31: p = rgb(5'd21, 5'd25, 5'd29);
            6'h32: p = rgb(5'd23, 5'd23, 5'd29);
            6'h33: p = rgb(5'd26, 5'd22, 5'd29);
            6'h34: p = rgb(5'd29, 5'd21, 5'd29);
            6'h35: p = rgb(5'd29, 5'd21, 5'd26);
            6'h36: p = rgb(5'd29, 5'd22, 5'd22);
            6'h37: p = rgb(5'd28, 5'd24, 5'd18);
            6'h38: p = rgb(5'd25, 5'd26, 5'd15);
            6'h39: p = rgb(5'd22, 5'd27, 5'd15);
            6'h3A: p = rgb(5'd21, 5'd28, 5'd18);
            6'h3B: p = rgb(5'd19, 5'd28, 5'd22);
            6'h3C: p = rgb(5'd20, 5'd26, 5'd28);
            6'h3D: p = rgb(5'd20, 5'd20, 5'd20);
            default: p = 15'h0000;  // 0x0D-0F, 0x1D-1F, 0x2E-2F, 0x3E-3F are black
        endcase
        return p;
    endfunction

    // Next-state: bank swap, ready tracking, swap counter, overrun, sync, read index.
    always_comb begin
        wr_bank_d    = wr_bank_q;
        line_ready_d = line_ready_q;
        overrun_d    = overrun_q;
        cnt_base     = rd_line_start ? 2'd0 : swap_cnt_q;  // clear first, then count
        swap_cnt_d   = cnt_base;
        if (in_line_done) begin
            wr_bank_d    = ~wr_bank_q;
            line_ready_d = 1'b1;
            if (cnt_base == 2'd2) begin
                overrun_d = 1'b1;
            end
            if (cnt_base != 2'd3) begin
                swap_cnt_d = cnt_base + 2'd1;
            end
        end
        // Frame start wins over a coincident line_done for readiness only.
        if (in_frame_start) begin
            line_ready_d = 1'b0;
        end
        sync_d     = in_frame_start;
        rd_valid_d = line_ready_q;
        rd_idx_d   = line_mem[{~wr_bank_q, rd_x[8:1]}];
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q    <= 1'b0;
            line_ready_q <= 1'b0;
            swap_cnt_q   <= 2'd0;
            overrun_q    <= 1'b0;
            sync_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            wr_bank_q    <= wr_bank_d;
            line_ready_q <= line_ready_d;
            swap_cnt_q   <= swap_cnt_d;
            overrun_q    <= overrun_d;
            sync_q       <= sync_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Line RAM: writes go to the writer bank (pre-swap bank on a coincident line_done);
    // contents survive reset, and reset blocks writes.
    always_ff @(posedge clk) begin
        if (!reset && in_ce) begin
            line_mem[{wr_bank_q, in_x}] <= in_color;
        end
        rd_idx_q <= rd_idx_d;
    end

    assign pixel   = rd_valid_q ? pal_lookup(rd_idx_q) : PAL_BLACK;
    assign sync    = sync_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_scan_line_buffer.sv
// Directed bench for scan_line_buffer: each task drives one scenario and
// checks the outputs inline against hand-computed values.
module tb_scan_line_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_ce;
  logic [7:0]  in_x;
  logic [5:0]  in_color;
  logic        in_line_done;
  logic        in_frame_start;
  logic [8:0]  rd_x;
  logic        rd_line_start;
  logic [14:0] pixel;
  logic        sync;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [14:0] WHITE = 15'h7FFF;
  localparam logic [14:0] BLACK = 15'h0000;

  scan_line_buffer #(.PAL_BLACK(15'h0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_ce          (in_ce),
    .in_x           (in_x),
    .in_color       (in_color),
    .in_line_done   (in_line_done),
    .in_frame_start (in_frame_start),
    .rd_x           (rd_x),
    .rd_line_start  (rd_line_start),
    .pixel          (pixel),
    .sync           (sync),
    .overrun        (overrun)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // one clock: inputs driven before the edge, outputs settle 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic fill_line(input logic [5:0] c);
    in_ce = 1'b1;
    in_color = c;
    for (int i = 0; i < 256; i++) begin
      in_x = i[7:0];
      tick();
    end
    in_ce = 1'b0;
  endtask

  task automatic write_pix(input logic [7:0] x, input logic [5:0] c);
    in_ce = 1'b1;
    in_x = x;
    in_color = c;
    tick();
    in_ce = 1'b0;
  endtask

  task automatic pulse_line_done();
    in_line_done = 1'b1;
    tick();
    in_line_done = 1'b0;
  endtask

  task automatic pulse_rd_line_start();
    rd_line_start = 1'b1;
    tick();
    rd_line_start = 1'b0;
  endtask

  // drive rd_x for one cycle; pixel is valid after the tick
  task automatic read_px(input logic [8:0] x);
    rd_x = x;
    tick();
  endtask

  task automatic test_reset();
    // reset overrides every strobe in the same cycle
    reset = 1'b1;
    in_ce = 1'b1;
    in_line_done = 1'b1;
    in_frame_start = 1'b1;
    tick();
    tick();
    in_ce = 1'b0;
    in_line_done = 1'b0;
    in_frame_start = 1'b0;
    reset = 1'b0;
    n_cmp++;
    if (sync !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sync got %0b want 0", sync);
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_overrun got %0b want 0", overrun);
    end
    n_cmp++;
    if (pixel !== BLACK) begin
      n_err++;
      $display("FAIL reset_pixel got %h want %h", pixel, BLACK);
    end
    tick();
    n_cmp++;
    if (sync !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sync_after got %0b want 0", sync);
    end
  endtask

  task automatic test_black_before_ready();
    do_reset();
    fill_line(6'h30);
    read_px(9'd0);
    n_cmp++;
    if (pixel !== BLACK) begin
      n_err++;
      $display("FAIL notready_x0 got %h want %h", pixel, BLACK);
    end
    read_px(9'd100);
    n_cmp++;
    if (pixel !== BLACK) begin
      n_err++;
      $display("FAIL notready_x100 got %h want %h", pixel, BLACK);
    end
    read_px(9'd511);
    n_cmp++;
    if (pixel !== BLACK) begin
      n_err++;
      $display("FAIL notready_x511 got %h want %h", pixel, BLACK);
    end
  endtask

  task automatic test_basic_line();
    do_reset();
    fill_line(6'h30);
    pulse_line_done();
    read_px(9'd0);
    n_cmp++;
    if (pixel !== WHITE) begin
      n_err++;
      $display("FAIL basic_x0 got %h want %h", pixel, WHITE);
    end
    read_px(9'd511);
    n_cmp++;
    if (pixel !== WHITE) begin
      n_err++;
      $display("FAIL basic_x511 got %h want %h", pixel, WHITE);
    end
  endtask

  task automatic test_doubling();
    // continues from test_basic_line: writer is now bank 1
    pulse_rd_line_start();
    fill_line(6'h0F);
    write_pix(8'd5, 6'h20);
    pulse_line_done();
    read_px(9'd10);
    n_cmp++;
    if (pixel !== WHITE) begin
      n_err++;
      $display("FAIL double_x10 got %h want %h", pixel, WHITE);
    end
    read_px(9'd11);
    n_cmp++;
    if (pixel !== WHITE) begin
      n_err++;
      $display("FAIL double_x11 got %h want %h", pixel, WHITE);
    end
    read_px(9'd12);
    n_cmp++;
    if (pixel !== BLACK) begin
      n_err++;
      $display("FAIL double_x12 got %h want %h", pixel, BLACK);
    end
    read_px(9'd9);
    n_cmp++;
    if (pixel !== BLACK) begin
      n_err++;
      $display("FAIL double_x9 got %h want %h", pixel, BLACK);
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL double_overrun got %0b want 0", overrun);
    end
  endtask

  task automatic test_frame_start();
    do_reset();
    fill_line(6'h30);
    pulse_line_done();            // bank0 ready, writer bank1
    pulse_rd_line_start();
    rd_x = 9'd10;
    in_frame_start = 1'b1;
    tick();                       // edge N
    in_frame_start = 1'b0;
    n_cmp++;
    if (sync !== 1'b1) begin
      n_err++;
      $display("FAIL fs_sync_n1 got %0b want 1", sync);
    end
    tick();
    n_cmp++;
    if (sync !== 1'b0) begin
      n_err++;
      $display("FAIL fs_sync_n2 got %0b want 0", sync);
    end
    n_cmp++;
    if (pixel !== BLACK) begin
      n_err++;
      $display("FAIL fs_pixel_n2 got %h want %h", pixel, BLACK);
    end
    fill_line(6'h30);             // writer bank1, still not ready
    read_px(9'd10);
    n_cmp++;
    if (pixel !== BLACK) begin
      n_err++;
      $display("FAIL fs_pixel_wait got %h want %h", pixel, BLACK);
    end
    // frame start coincident with line done: swap happens, stays not ready
    pulse_rd_line_start();
    in_frame_start = 1'b1;
    in_line_done = 1'b1;
    tick();
    in_frame_start = 1'b0;
    in_line_done = 1'b0;
    tick();
    read_px(9'd10);
    n_cmp++;
    if (pixel !== BLACK) begin
      n_err++;
      $display("FAIL fs_coincident_pixel got %h want %h", pixel, BLACK);
    end
    // writer is bank0 now; write black and swap -> bank0 visible
    fill_line(6'h0F);
    write_pix(8'd3, 6'h20);
    pulse_line_done();
    read_px(9'd6);
    n_cmp++;
    if (pixel !== WHITE) begin
      n_err++;
      $display("FAIL fs_ready_x6 got %h want %h", pixel, WHITE);
    end
    read_px(9'd8);
    n_cmp++;
    if (pixel !== BLACK) begin
      n_err++;
      $display("FAIL fs_ready_x8 got %h want %h", pixel, BLACK);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    pulse_line_done();
    pulse_line_done();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_after2 got %0b want 0", overrun);
    end
    pulse_line_done();
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_after3 got %0b want 1", overrun);
    end
    pulse_rd_line_start();
    write_pix(8'd1, 6'h01);
    pulse_line_done();
    in_frame_start = 1'b1;
    tick();
    in_frame_start = 1'b0;
    tick();
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_sticky got %0b want 1", overrun);
    end
    do_reset();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_reset got %0b want 0", overrun);
    end
    // rd_line_start between swaps keeps the counter below the limit
    pulse_line_done();
    pulse_line_done();
    pulse_rd_line_start();
    pulse_line_done();
    pulse_line_done();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_cleared got %0b want 0", overrun);
    end
    pulse_line_done();
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_cleared_3rd got %0b want 1", overrun);
    end
  endtask

  task automatic test_coincident_start_done();
    do_reset();
    // coincident rd_line_start + line_done leaves counter at 1
    pulse_line_done();
    pulse_line_done();            // counter 2
    rd_line_start = 1'b1;
    in_line_done = 1'b1;
    tick();                       // counter 1
    rd_line_start = 1'b0;
    in_line_done = 1'b0;
    pulse_line_done();            // counter 2
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL coinc_cnt_no_ovr got %0b want 0", overrun);
    end
    pulse_line_done();            // swap at 2 -> overrun
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL coinc_cnt_ovr got %0b want 1", overrun);
    end
  endtask

  task automatic test_back_to_back_write_swap();
    do_reset();
    fill_line(6'h0F);
    pulse_line_done();            // bank0 visible, writer bank1
    fill_line(6'h0F);
    in_ce = 1'b1;
    in_x = 8'd7;
    in_color = 6'h20;
    in_line_done = 1'b1;
    tick();
    in_ce = 1'b0;
    in_line_done = 1'b0;
    read_px(9'd14);
    n_cmp++;
    if (pixel !== WHITE) begin
      n_err++;
      $display("FAIL coinc_wr_x14 got %h want %h", pixel, WHITE);
    end
    read_px(9'd15);
    n_cmp++;
    if (pixel !== WHITE) begin
      n_err++;
      $display("FAIL coinc_wr_x15 got %h want %h", pixel, WHITE);
    end
    read_px(9'd16);
    n_cmp++;
    if (pixel !== BLACK) begin
      n_err++;
      $display("FAIL coinc_wr_x16 got %h want %h", pixel, BLACK);
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    fill_line(6'h30);             // bank0 all white
    reset = 1'b1;
    in_ce = 1'b1;
    in_x = 8'd3;
    in_color = 6'h0F;
    in_line_done = 1'b1;
    in_frame_start = 1'b1;
    tick();
    reset = 1'b0;
    in_ce = 1'b0;
    in_line_done = 1'b0;
    in_frame_start = 1'b0;
    n_cmp++;
    if (sync !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_sync got %0b want 0", sync);
    end
    tick();
    n_cmp++;
    if (sync !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_sync_next got %0b want 0", sync);
    end
    pulse_line_done();            // bank0 becomes visible
    read_px(9'd6);
    n_cmp++;
    if (pixel !== WHITE) begin
      n_err++;
      $display("FAIL midrst_x6 got %h want %h", pixel, WHITE);
    end
    read_px(9'd300);
    n_cmp++;
    if (pixel !== WHITE) begin
      n_err++;
      $display("FAIL midrst_x300 got %h want %h", pixel, WHITE);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_ce = 1'b0;
    in_x = 8'd0;
    in_color = 6'd0;
    in_line_done = 1'b0;
    in_frame_start = 1'b0;
    rd_x = 9'd0;
    rd_line_start = 1'b0;
    test_reset();
    test_black_before_ready();
    test_basic_line();
    test_doubling();
    test_frame_start();
    test_overrun();
    test_coincident_start_done();
    test_back_to_back_write_swap();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
